fb_mult_sequencer: RTL and testbench
====================================

# fb_mult_sequencer

Sequencer for the bunch-by-bunch feedback multiplier datapath. It generates the `store_strb`, `bunch_strb` and `delay_en` controls that the multiplier consumes, from a single machine trigger and a register-loaded configuration. It also flags when the multiplier's 13-bit output is valid. It sits between the trigger/register-bank logic and the multiplier instance, one sequencer per multiplier.

## Interface
- `NUM_SMPLS_INTEG`, default 4: samples integrated per bunch; minimum bunch spacing.
- `MULT_LATENCY`, default 3: cycles from `store_strb` input sample to multiplier output.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  single-cycle pulse; latches config and enters ARMED.
- `abort`  in  1  single-cycle pulse; terminates any sequence.
- `trig`  in  1  single-cycle machine trigger.
- `cfg_num_bunches`  in  8  bunches per train (0 = empty train).
- `cfg_spacing`  in  8  cycles per bunch.
- `cfg_start_delay`  in  16  cycles from trigger to first bunch.
- `cfg_delay_mask`  in  16  per-bunch `delay_en` enable; bit i applies to bunch i; bunches ≥15 use bit 15.
- `store_strb`  out  1  to multiplier; high for the whole train.
- `bunch_strb`  out  1  to multiplier; high on the first cycle of each bunch.
- `delay_en`  out  1  to multiplier; mask bit of the current bunch.
- `bunch_idx`  out  8  current bunch number, 0-based.
- `dsp_valid`  out  1  multiplier output is valid this cycle.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at train completion.
- `overrun`  out  1  sticky; a trigger was received while not ARMED but busy; cleared by `arm` or `rst`.

## Operation
- States: IDLE, ARMED, WAIT, RUN.
- IDLE:
  - `arm` latches all `cfg_*` into shadow registers and moves to ARMED.
  - `trig` is ignored.
- ARMED:
  - On `trig`: if `cfg_start_delay` = 0, go to RUN; else load the delay counter and go to WAIT.
  - A repeated `arm` re-latches the config.
- WAIT:
  - Count down `cfg_start_delay` cycles, then go to RUN.
  - First RUN cycle is exactly `cfg_start_delay` + 1 cycles after the `trig` cycle.
- RUN:
  - `store_strb` = 1.
  - Sample counter runs 0..spacing-1; `bunch_strb` = 1 when sample counter = 0.
  - `bunch_idx` increments when the sample counter wraps.
  - When `bunch_idx` = num_bunches-1 and the sample counter = spacing-1: pulse `done` on the following cycle and go to IDLE.
- Empty train: num_bunches = 0 means a trigger in ARMED goes straight to IDLE with a `done` pulse; `store_strb` never asserts.
- Spacing clamp: latched spacing below `NUM_SMPLS_INTEG` is clamped to `NUM_SMPLS_INTEG` at latch time.
- `delay_en` = `cfg_delay_mask[min(bunch_idx,15)]` during RUN, 0 otherwise.
- `dsp_valid`: `store_strb` has been high for the last `MULT_LATENCY`+1 consecutive cycles, including the current one. The multiplier zeroes its output once `store_strb` drops, so the tail `MULT_LATENCY` samples are never flagged valid.
- Events:
  - `abort` from any state: IDLE next cycle, no `done`, and all outputs except `overrun` go to 0.
  - `trig` in WAIT or RUN is ignored and sets `overrun`.
  - `arm` and `trig` in the same cycle while ARMED: the new config is latched and the trigger is honoured with the new config.
  - `abort` has priority over `arm` and `trig`.

## Timing
- Reset values: `store_strb`, `bunch_strb`, `delay_en`, `dsp_valid`, `busy`, `done`, `overrun` = 0; `bunch_idx` = 0; state IDLE; shadow config = 0.
- `rst` mid-train: all outputs 0 on the next edge, with no `done`.
- All outputs are registered.
- `store_strb` rises on the first RUN cycle, together with `bunch_strb` and `bunch_idx` = 0.
- `store_strb` is high for exactly num_bunches × spacing cycles.
- Train-to-train: a new `arm` is accepted in the cycle after `done`.
- Counter widths:
  - Sample counter: 8 bits.
  - Bunch counter: 8 bits.
  - Delay counter: 16 bits.
  - No wrap is possible within the legal config range.

## Test plan
- Basic train: arm with num=3, spacing=4, delay=0, then trig at cycle T. Required:
  - `store_strb` high for T+1..T+12.
  - `bunch_strb` at T+1, T+5, T+9.
  - `done` at T+13.
  - `dsp_valid` high for T+4..T+12.
- Start delay and mask: delay=10, mask=0b101, num=3, spacing=8. Required:
  - First `bunch_strb` at T+11.
  - `delay_en` high in bunches 0 and 2 only.
- Clamp and empty train:
  - spacing=2 with `NUM_SMPLS_INTEG`=4: bunch period is 4 cycles.
  - num=0: `done` one cycle after trig, `store_strb` never high.
- Overrun: a second trig during RUN. Required:
  - Train completes unchanged and `overrun` = 1.
  - Next `arm` clears `overrun`.
- Abort and reset mid-RUN:
  - `abort` at bunch 1: all outputs 0 next cycle, no `done`.
  - Repeat with `rst`: same result, and `overrun` is cleared.
- `arm`+`trig` same cycle in ARMED: the new spacing value is used for the train.

Source files
------------

// File: rtl/fb_mult_sequencer.sv
// Trigger-driven sequencer producing store/bunch/delay strobes for the feedback
// multiplier, plus output-valid tracking across the multiplier pipeline.
module fb_mult_sequencer #(
  parameter int NUM_SMPLS_INTEG = 4,
  parameter int MULT_LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        abort,
  input  logic        trig,
  input  logic [7:0]  cfg_num_bunches,
  input  logic [7:0]  cfg_spacing,
  input  logic [15:0] cfg_start_delay,
  input  logic [15:0] cfg_delay_mask,
  output logic        store_strb,
  output logic        bunch_strb,
  output logic        delay_en,
  output logic [7:0]  bunch_idx,
  output logic        dsp_valid,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;
  localparam logic [7:0] MIN_SPACING = 8'(NUM_SMPLS_INTEG);

  // Bunches beyond 15 share the top mask bit.
  function automatic logic mask_bit(input logic [15:0] mask, input logic [7:0] idx);
    logic [3:0] sel;
    if (idx > 8'd15) begin
      sel = 4'd15;
    end else begin
      sel = idx[3:0];
    end
    return mask[sel];
  endfunction

  logic [1:0]  state_q, state_d;
  logic [7:0]  samp_q, samp_d;
  logic [7:0]  bidx_q, bidx_d;
  logic [15:0] dly_q, dly_d;
  logic [7:0]  num_q, num_d;
  logic [7:0]  spacing_q, spacing_d;
  logic [15:0] delay_q, delay_d;
  logic [15:0] mask_q, mask_d;
  logic [MULT_LATENCY:0] hist_q, hist_d;
  logic        store_q, store_d;
  logic        bunch_q, bunch_d;
  logic        den_q, den_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        arm_ok;
  logic        run_d;

  // Next-state, shadow-config and registered-output computation.
  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bidx_d    = bidx_q;
    dly_d     = dly_q;
    done_d    = 1'b0;
    arm_ok    = arm && !abort && (state_q == S_IDLE || state_q == S_ARMED);

    // Config is latched first so a same-cycle trigger sees the new values.
    if (arm_ok) begin
      num_d     = cfg_num_bunches;
      spacing_d = (cfg_spacing < MIN_SPACING) ? MIN_SPACING : cfg_spacing;
      delay_d   = cfg_start_delay;
      mask_d    = cfg_delay_mask;
    end else begin
      num_d     = num_q;
      spacing_d = spacing_q;
      delay_d   = delay_q;
      mask_d    = mask_q;
    end

    case (state_q)
      S_IDLE: begin
        if (arm_ok) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (trig) begin
          samp_d = 8'd0;
          bidx_d = 8'd0;
          if (num_d == 8'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (delay_d == 16'd0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_WAIT;
            dly_d   = delay_d - 16'd1;
          end
        end else begin
          state_d = S_ARMED;
        end
      end
      S_WAIT: begin
        if (dly_q == 16'd0) begin
          state_d = S_RUN;
          samp_d  = 8'd0;
          bidx_d  = 8'd0;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end
      S_RUN: begin
        if (samp_q == spacing_q - 8'd1) begin
          samp_d = 8'd0;
          if (bidx_q == num_q - 8'd1) begin
            state_d = S_IDLE;
            bidx_d  = 8'd0;
            done_d  = 1'b1;
          end else begin
            bidx_d = bidx_q + 8'd1;
          end
        end else begin
          samp_d = samp_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        samp_d  = 8'd0;
        bidx_d  = 8'd0;
      end
    endcase

    if (abort) begin
      overrun_d = overrun_q;
    end else if (trig && (state_q == S_WAIT || state_q == S_RUN)) begin
      overrun_d = 1'b1;
    end else if (arm) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (abort) begin
      state_d = S_IDLE;
      samp_d  = 8'd0;
      bidx_d  = 8'd0;
      dly_d   = 16'd0;
      done_d  = 1'b0;
    end else begin
      dly_d = dly_d;
    end

    run_d   = (state_d == S_RUN);
    store_d = run_d;
    bunch_d = run_d && (samp_d == 8'd0);
    den_d   = run_d && mask_bit(mask_d, bidx_d);
    busy_d  = (state_d != S_IDLE);
    // Valid only after MULT_LATENCY+1 unbroken store cycles, so history clears on any gap.
    if (run_d) begin
      hist_d = {hist_q[MULT_LATENCY-1:0], 1'b1};
    end else begin
      hist_d = '0;
    end
    valid_d = &hist_d;
  end

  // State, counters, shadow config and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      samp_q    <= 8'd0;
      bidx_q    <= 8'd0;
      dly_q     <= 16'd0;
      num_q     <= 8'd0;
      spacing_q <= 8'd0;
      delay_q   <= 16'd0;
      mask_q    <= 16'd0;
      hist_q    <= '0;
      store_q   <= 1'b0;
      bunch_q   <= 1'b0;
      den_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      bidx_q    <= bidx_d;
      dly_q     <= dly_d;
      num_q     <= num_d;
      spacing_q <= spacing_d;
      delay_q   <= delay_d;
      mask_q    <= mask_d;
      hist_q    <= hist_d;
      store_q   <= store_d;
      bunch_q   <= bunch_d;
      den_q     <= den_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign store_strb = store_q;
  assign bunch_strb = bunch_q;
  assign delay_en   = den_q;
  assign bunch_idx  = bidx_q;
  assign dsp_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fb_mult_sequencer.sv
// Scoreboard bench for fb_mult_sequencer: stimulus pushes expected bunch/done
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_fb_mult_sequencer;

  localparam int L = 3;

  logic        clk, rst, arm, abort, trig;
  logic [7:0]  cfg_num_bunches, cfg_spacing;
  logic [15:0] cfg_start_delay, cfg_delay_mask;
  logic        store_strb, bunch_strb, delay_en, dsp_valid, busy, done, overrun;
  logic [7:0]  bunch_idx;

  fb_mult_sequencer #(.NUM_SMPLS_INTEG(4), .MULT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .cfg_num_bunches(cfg_num_bunches), .cfg_spacing(cfg_spacing),
    .cfg_start_delay(cfg_start_delay), .cfg_delay_mask(cfg_delay_mask),
    .store_strb(store_strb), .bunch_strb(bunch_strb), .delay_en(delay_en),
    .bunch_idx(bunch_idx), .dsp_valid(dsp_valid), .busy(busy), .done(done),
    .overrun(overrun)
  );

  typedef struct {
    int kind;   // 0 = bunch strobe, 1 = done
    int cyc;
    int idx;
    int en;
    int st;
    int vd;
    int ens;
    int ovr;
    int first;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   st_cnt = 0, vd_cnt = 0, en_cnt = 0, first_st = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Expected events for one train; bunch period is the already-clamped spacing.
  task automatic push_train(input int t, input int num, input int sp, input int dly,
                            input logic [15:0] mask, input int ovr, input int limit);
    exp_t e;
    int start, ens, st;
    start = t + dly + 1;
    ens = 0;
    for (int b = 0; b < num; b++) begin
      e = '{0, start + b * sp, b, int'(mask[(b > 15) ? 15 : b]), 0, 0, 0, 0, 0};
      ens += e.en * sp;
      if (b < limit) sb.push_back(e);
    end
    st = num * sp;
    if (limit >= num) begin
      e = '{1, (num == 0) ? t + 1 : start + st, 0, 0, st, (st > L) ? st - L : 0,
            ens, ovr, (num == 0) ? -1 : start};
      sb.push_back(e);
    end
  endtask

  // Monitor: window counters plus event pop/compare.
  always @(negedge clk) begin
    exp_t e;
    if (store_strb === 1'b1) begin
      if (st_cnt == 0) first_st = cyc;
      st_cnt++;
    end
    if (dsp_valid === 1'b1) vd_cnt++;
    if (delay_en === 1'b1) en_cnt++;
    if (bunch_strb === 1'b1 || done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {30'd0, bunch_strb, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("evt_kind", {31'd0, done}, e.kind);
        chk("evt_cycle", cyc, e.cyc);
        if (e.kind == 0) begin
          chk("bunch_idx", bunch_idx, e.idx);
          chk("bunch_delay_en", {31'd0, delay_en}, e.en);
          chk("bunch_store", {31'd0, store_strb}, 32'd1);
        end else begin
          chk("store_cycles", st_cnt, e.st);
          chk("valid_cycles", vd_cnt, e.vd);
          chk("delay_en_cycles", en_cnt, e.ens);
          chk("first_store", first_st, e.first);
          chk("overrun_at_done", {31'd0, overrun}, e.ovr);
        end
      end
    end
    if (busy !== 1'b1 && done !== 1'b1) begin
      st_cnt = 0; vd_cnt = 0; en_cnt = 0; first_st = -1;
    end
  end

  task automatic do_arm(input int num, input int sp, input int dly, input logic [15:0] mask);
    @(negedge clk);
    cfg_num_bunches = 8'(num); cfg_spacing = 8'(sp);
    cfg_start_delay = 16'(dly); cfg_delay_mask = mask;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic do_trig(output int t);
    @(negedge clk);
    trig = 1'b1;
    t = cyc;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_quiet(input string name, input logic exp_ovr);
    chk(name, {store_strb, bunch_strb, delay_en, dsp_valid, busy, done, overrun, bunch_idx},
        {6'd0, exp_ovr, 8'd0});
  endtask

  initial begin
    int t, t2;
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    cfg_num_bunches = 8'd0; cfg_spacing = 8'd0;
    cfg_start_delay = 16'd0; cfg_delay_mask = 16'd0;
    repeat (3) @(negedge clk);
    chk_quiet("reset_outputs", 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic train: bunches T+1/5/9, done T+13, 12 store, 9 valid.
    do_arm(3, 4, 0, 16'h0000);
    chk("armed_busy", {31'd0, busy}, 32'd1);
    do_trig(t);
    push_train(t, 3, 4, 0, 16'h0000, 0, 99);
    wait_drain();

    // Start delay and mask: first bunch T+11, delay_en in bunches 0 and 2.
    do_arm(3, 8, 10, 16'b101);
    do_trig(t);
    push_train(t, 3, 8, 10, 16'b101, 0, 99);
    wait_drain();

    // Spacing 2 clamps to 4.
    do_arm(2, 2, 0, 16'hFFFF);
    do_trig(t);
    push_train(t, 2, 4, 0, 16'hFFFF, 0, 99);
    wait_drain();

    // Empty train: done at T+1, no store.
    do_arm(0, 4, 5, 16'h0000);
    do_trig(t);
    push_train(t, 0, 4, 5, 16'h0000, 0, 99);
    wait_drain();

    // Overrun: second trigger in RUN leaves the train intact, next arm clears.
    do_arm(3, 4, 0, 16'h0002);
    do_trig(t);
    push_train(t, 3, 4, 0, 16'h0002, 1, 99);
    do_trig(t2);
    wait_drain();
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);
    do_arm(1, 4, 0, 16'h0000);
    chk("overrun_cleared_by_arm", {31'd0, overrun}, 32'd0);

    // arm+trig together in ARMED: new spacing 5 used.
    @(negedge clk);
    cfg_num_bunches = 8'd2; cfg_spacing = 8'd5;
    cfg_start_delay = 16'd0; cfg_delay_mask = 16'h0001;
    arm = 1'b1; trig = 1'b1; t = cyc;
    @(negedge clk);
    arm = 1'b0; trig = 1'b0;
    push_train(t, 2, 5, 0, 16'h0001, 0, 99);
    wait_drain();

    // Abort at bunch 1: outputs drop, overrun kept, no done.
    do_arm(3, 4, 0, 16'hFFFF);
    do_trig(t);
    push_train(t, 3, 4, 0, 16'hFFFF, 0, 2);
    do_trig(t2);
    repeat (2) @(negedge clk);
    chk("abort_at_bunch1_idx", bunch_idx, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_quiet("abort_outputs", 1'b1);
    wait_drain();

    // Reset at bunch 1: outputs drop and overrun clears.
    do_arm(3, 4, 0, 16'hFFFF);
    chk("arm_clears_overrun", {31'd0, overrun}, 32'd0);
    do_trig(t);
    push_train(t, 3, 4, 0, 16'hFFFF, 0, 2);
    do_trig(t2);
    repeat (2) @(negedge clk);
    chk("rst_pre_overrun", {31'd0, overrun}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("rst_outputs", 1'b0);
    wait_drain();

    // Train-to-train after reset still works.
    do_arm(1, 4, 1, 16'h0001);
    do_trig(t);
    push_train(t, 1, 4, 1, 16'h0001, 0, 99);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
